// File: rtl/sbus_to_ahbl.sv
// SBUS responder issuing one single AHB-Lite manager transfer per request.
// Optional SBUS2AHBL_FAST_RESP_EN: completion is reported combinationally during the data phase.
module sbus_to_ahbl #(
    parameter int         W_ADDR    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] sbus_addr,
    input  logic              sbus_write,
    input  logic [1:0]        sbus_size,
    input  logic              sbus_vld,
    input  logic [31:0]       sbus_wdata,
    output logic              sbus_rdy,
    output logic              sbus_err,
    output logic [31:0]       sbus_rdata,
    output logic [W_ADDR-1:0] ahblm_haddr,
    output logic              ahblm_hwrite,
    output logic [1:0]        ahblm_htrans,
    output logic [2:0]        ahblm_hsize,
    output logic [2:0]        ahblm_hburst,
    output logic [3:0]        ahblm_hprot,
    output logic              ahblm_hmastlock,
    input  logic              ahblm_hready,
    input  logic              ahblm_hresp,
    output logic [31:0]       ahblm_hwdata,
    input  logic [31:0]       ahblm_hrdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]        state_q,  state_d;
    logic [W_ADDR-1:0] haddr_q,  haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        hsize_q,  hsize_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              err_q,    err_d;
    logic              req_illegal;

    always_comb begin
        req_illegal = (sbus_size == 2'd3)
                    | ((sbus_size == 2'd1) & sbus_addr[0])
                    | ((sbus_size == 2'd2) & (|sbus_addr[1:0]));
    end

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sbus_vld) begin
                    haddr_d  = sbus_addr;
                    hwrite_d = sbus_write;
                    hsize_d  = sbus_size;
                    // Illegal requests never reach the fabric; they are answered locally.
                    err_d    = req_illegal;
                    state_d  = req_illegal ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ahblm_hready) begin
                    hwdata_d = sbus_wdata;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // A two-phase ERROR first shows hresp with hready low; only the hready cycle counts.
                if (ahblm_hready) begin
                    if (!hwrite_q) begin
                        rdata_d = ahblm_hrdata;
                    end
                    err_d = ahblm_hresp;
`ifdef SBUS2AHBL_FAST_RESP_EN
                    state_d = ST_IDLE;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahblm_hsize     = {1'b0, hsize_q};
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = HPROT_VAL;
    assign ahblm_hmastlock = 1'b0;
    assign ahblm_hwdata    = hwdata_q;

`ifdef SBUS2AHBL_FAST_RESP_EN
    // RESP is only reached by illegal requests in this build.
    assign sbus_rdy   = (state_q == ST_RESP) | ((state_q == ST_DATA) & ahblm_hready);
    assign sbus_err   = (state_q == ST_DATA) ? ahblm_hresp  : err_q;
    assign sbus_rdata = (state_q == ST_DATA) ? ahblm_hrdata : rdata_q;
`else
    assign sbus_rdy   = (state_q == ST_RESP);
    assign sbus_err   = err_q;
    assign sbus_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sbus_to_ahbl.sv
// Directed bench for sbus_to_ahbl: drives SBUS requests and plays a simple AHB-Lite slave.
module tb_sbus_to_ahbl;

`ifdef SBUS2AHBL_FAST_RESP_EN
    localparam int  LAT  = 2;
    localparam bit  FAST = 1'b1;
`else
    localparam int  LAT  = 3;
    localparam bit  FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sbus_addr;
    logic        sbus_write;
    logic [1:0]  sbus_size;
    logic        sbus_vld;
    logic [31:0] sbus_wdata;
    logic        sbus_rdy;
    logic        sbus_err;
    logic [31:0] sbus_rdata;
    logic [31:0] ahblm_haddr;
    logic        ahblm_hwrite;
    logic [1:0]  ahblm_htrans;
    logic [2:0]  ahblm_hsize;
    logic [2:0]  ahblm_hburst;
    logic [3:0]  ahblm_hprot;
    logic        ahblm_hmastlock;
    logic        ahblm_hready;
    logic        ahblm_hresp;
    logic [31:0] ahblm_hwdata;
    logic [31:0] ahblm_hrdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd = 32'h0;
    bit   prev_nonseq = 1'b0;
    int   consec_ns = 0;
    int   rdy_total = 0;

    sbus_to_ahbl #(.W_ADDR(32), .HPROT_VAL(4'b0011)) dut (
        .clk(clk), .rst_n(rst_n),
        .sbus_addr(sbus_addr), .sbus_write(sbus_write), .sbus_size(sbus_size),
        .sbus_vld(sbus_vld), .sbus_wdata(sbus_wdata),
        .sbus_rdy(sbus_rdy), .sbus_err(sbus_err), .sbus_rdata(sbus_rdata),
        .ahblm_haddr(ahblm_haddr), .ahblm_hwrite(ahblm_hwrite), .ahblm_htrans(ahblm_htrans),
        .ahblm_hsize(ahblm_hsize), .ahblm_hburst(ahblm_hburst), .ahblm_hprot(ahblm_hprot),
        .ahblm_hmastlock(ahblm_hmastlock), .ahblm_hready(ahblm_hready), .ahblm_hresp(ahblm_hresp),
        .ahblm_hwdata(ahblm_hwdata), .ahblm_hrdata(ahblm_hrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic track_htrans();
        bit ns;
        ns = (ahblm_htrans == 2'b10);
        if (ns && prev_nonseq) consec_ns++;
        prev_nonseq = ns;
    endtask

    // One SBUS request; cycle 0 is the cycle vld is first presented.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [1:0] sz, input logic [31:0] wd, input int waits,
                        input logic slv_err, input logic [31:0] slv_rdata,
                        input logic exp_err, input bit exp_ahb, input bit chain);
        int   ns_cnt = 0;
        int   ns_cycle = -1;
        int   rdy_cycle = -1;
        int   rdy_cnt = 0;
        bit   acc_prev = 1'b0;
        bit   in_data = 1'b0;
        int   wleft = 0;
        int   exp_rdy;
        exp_rdy = exp_ahb ? (LAT + waits) : 1;

        @(posedge clk); #1;
        sbus_vld = 1'b1; sbus_addr = addr; sbus_write = wr; sbus_size = sz;
        sbus_wdata = 32'h0;
        ahblm_hready = 1'b1; ahblm_hresp = 1'b0; ahblm_hrdata = 32'h0;
        #1;
        track_htrans();
        if (sbus_rdy) rdy_cnt++;

        for (int c = 1; c <= 30 && rdy_cycle < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) sbus_wdata = wd;
            if (acc_prev) begin
                in_data = 1'b1;
                wleft = waits;
            end
            if (in_data) begin
                ahblm_hready = (wleft == 0);
                ahblm_hresp  = slv_err && (wleft <= 1);
                ahblm_hrdata = (wleft == 0 && !wr) ? slv_rdata : 32'h0;
            end else begin
                ahblm_hready = 1'b1;
                ahblm_hresp  = 1'b0;
                ahblm_hrdata = 32'h0;
            end
            #1;
            track_htrans();
            acc_prev = 1'b0;
            if (ahblm_htrans == 2'b10) begin
                ns_cnt++;
                if (ns_cycle < 0) begin
                    ns_cycle = c;
                    check({tag, "_haddr"},  ahblm_haddr, addr);
                    check({tag, "_hsize"},  ahblm_hsize, {1'b0, sz});
                    check({tag, "_hwrite"}, ahblm_hwrite, wr);
                end
                acc_prev = ahblm_hready;
            end
            if (in_data && wr) check({tag, "_hwdata"}, ahblm_hwdata, wd);
            if (sbus_rdy) begin
                rdy_cnt++;
                rdy_total++;
                rdy_cycle = c;
                check({tag, "_err"}, sbus_err, exp_err);
                if (exp_ahb && !wr && !exp_err) begin
                    check({tag, "_rdata"}, sbus_rdata, slv_rdata);
                    last_rd = slv_rdata;
                end else if (!FAST || !exp_ahb) begin
                    check({tag, "_rdata_kept"}, sbus_rdata, last_rd);
                end
            end
            if (in_data) begin
                if (ahblm_hready) in_data = 1'b0;
                else wleft--;
            end
        end

        check({tag, "_rdy_cycle"}, rdy_cycle, exp_rdy);
        check({tag, "_ns_count"}, ns_cnt, exp_ahb ? 1 : 0);
        if (exp_ahb) check({tag, "_ns_cycle"}, ns_cycle, 1);

        if (!chain) begin
            @(posedge clk); #1;
            sbus_vld = 1'b0; ahblm_hready = 1'b1; ahblm_hresp = 1'b0;
            #1;
            track_htrans();
            if (sbus_rdy) rdy_cnt++;
            check({tag, "_one_pulse"}, rdy_cnt, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sbus_addr = 32'h0; sbus_write = 1'b0; sbus_size = 2'd0;
        sbus_vld = 1'b0; sbus_wdata = 32'h0;
        ahblm_hready = 1'b1; ahblm_hresp = 1'b0; ahblm_hrdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_htrans", ahblm_htrans, 2'b00);
        check("rst_rdy", sbus_rdy, 1'b0);
        check("rst_err", sbus_err, 1'b0);
        check("rst_haddr", ahblm_haddr, 32'h0);
        check("rst_hwrite", ahblm_hwrite, 1'b0);
        check("rst_hsize", ahblm_hsize, 3'd0);
        check("rst_hwdata", ahblm_hwdata, 32'h0);
        check("rst_rdata", sbus_rdata, 32'h0);
        check("hburst", ahblm_hburst, 3'd0);
        check("hprot", ahblm_hprot, 4'b0011);
        check("hmastlock", ahblm_hmastlock, 1'b0);
        rst_n = 1'b1;

        xfer("rd_word", 32'h0000_1000, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        xfer("wr_byte", 32'h0000_2003, 1'b1, 2'd0, 32'h5A5A_5A5A, 3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        xfer("ill_half", 32'h0000_0001, 1'b0, 2'd1, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        xfer("ill_size3", 32'h0000_0000, 1'b0, 2'd3, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        xfer("ahb_err", 32'h0000_3000, 1'b1, 2'd2, 32'h1234_5678, 1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        xfer("after_err", 32'h0000_3004, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);

        // Reset pulsed while the address phase is stalled.
        @(posedge clk); #1;
        sbus_vld = 1'b1; sbus_addr = 32'h0000_0008; sbus_write = 1'b0; sbus_size = 2'd2;
        ahblm_hready = 1'b1;
        @(posedge clk); #1;
        ahblm_hready = 1'b0;
        #1;
        check("rst_addr_pre_htrans", ahblm_htrans, 2'b10);
        rst_n = 1'b0;
        #1;
        check("rst_addr_htrans", ahblm_htrans, 2'b00);
        check("rst_addr_haddr", ahblm_haddr, 32'h0);
        sbus_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ahblm_hready = 1'b1;

        // Reset pulsed during a stalled data phase.
        @(posedge clk); #1;
        sbus_vld = 1'b1; sbus_addr = 32'h0000_0008; sbus_write = 1'b0; sbus_size = 2'd2;
        ahblm_hready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ahblm_hready = 1'b0;
        #1;
        check("rst_data_pre_haddr", ahblm_haddr, 32'h0000_0008);
        rst_n = 1'b0;
        #1;
        check("rst_data_htrans", ahblm_htrans, 2'b00);
        check("rst_data_rdy", sbus_rdy, 1'b0);
        check("rst_data_haddr", ahblm_haddr, 32'h0);
        check("rst_data_rdata", sbus_rdata, 32'h0);
        last_rd = 32'h0;
        sbus_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ahblm_hready = 1'b1;
        xfer("rd_after_rst", 32'h0000_0004, 1'b0, 2'd2, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0);

        // Back-to-back reads: vld presented again in the cycle after each rdy.
        prev_nonseq = 1'b0;
        consec_ns = 0;
        rdy_total = 0;
        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("b2b%0d", i), 32'h0000_0100 + 32'(i * 4), 1'b0, 2'd2, 32'h0, 0,
                 1'b0, 32'hA500_0000 + 32'(i), 1'b0, 1'b1, (i != 9));
        end
        check("b2b_rdy_total", rdy_total, 10);
        check("b2b_consec_nonseq", consec_ns, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
